fruta_gen: RTL
==============

// Module: fruta_gen
// PURPOSE
//  Fruit-position generator feeding update: draws pseudo-random map cells, checks them empty via a
//  dedicated map read port, presents a validated (fruta_wx,fruta_wy). update consumes it with fruta_wenable.
//  Random draws first; after MAX_TRIES failures, row-major scan; fruta_cheio if no empty cell exists.
// PARAMETERS
//  MAPA_WIDTH   80       map columns; x range 0..MAPA_WIDTH-1 (<=1024)
//  MAPA_HEIGHT  60       map rows; y range 0..MAPA_HEIGHT-1 (<=1024)
//  SEED         16'hACE1 LFSR reset value; 0 is illegal and replaced by 16'hACE1
//  MAX_TRIES    32       random draws (in-range or not) before falling back to scan
// PORTS
//  clk            in   1   clock
//  reset          in   1   synchronous, active-low reset (0 = reset)
//  fruta_renable  out  1   map read strobe
//  fruta_rx       out  10  map read column
//  fruta_ry       out  10  map read row
//  fruta_rdata    in   2   cell value, valid cycle after strobe; 2'b00 = empty, else occupied
//  fruta_wx       out  10  validated fruit column (held while fruta_valid)
//  fruta_wy       out  10  validated fruit row
//  fruta_valid    out  1   fruta_wx/wy hold an empty-checked cell
//  fruta_wenable  in   1   1-cycle pulse from update: position consumed, generate next
//  fruta_cheio    out  1   sticky: scan found no empty cell
// BEHAVIOUR
//  Reset (reset==0 at posedge): all outputs 0, lfsr=SEED, tries=0, state=SORTEIA. Reset wins at any state.
//  LFSR: 16-bit Fibonacci, taps 16,14,13,11, shifts every cycle incl. reset release, never stalls.
//  Candidate: cx=lfsr[XB-1:0], cy=lfsr[15:16-YB]; XB=$clog2(MAPA_WIDTH), YB=$clog2(MAPA_HEIGHT); zero-extend.
//  SORTEIA: tries+=1. If cx<MAPA_WIDTH && cy<MAPA_HEIGHT: renable=1, rx/ry=cx/cy -> ESPERA.
//   Else stay. If tries reaches MAX_TRIES -> VARRE with scan x=y=0 (takes priority over draw).
//  ESPERA: renable=0; rdata==00 -> wx/wy=rx/ry, valid=1 -> PRONTO; else -> SORTEIA.
//  VARRE: renable=1, rx/ry=scan x/y -> VARRE_ESPERA.
//  VARRE_ESPERA: rdata==00 -> latch, valid=1 -> PRONTO. Else advance x; x wraps at MAPA_WIDTH-1 to 0
//   with y+1; occupied at (MAPA_WIDTH-1,MAPA_HEIGHT-1) -> cheio=1 -> CHEIO.
//  PRONTO: hold wx/wy, valid=1. fruta_wenable -> valid=0 next cycle, tries=0 -> SORTEIA.
//  CHEIO: cheio=1, valid=0, renable=0; stays until reset; fruta_wenable ignored.
//  fruta_wenable outside PRONTO ignored (no queuing). renable high exactly one cycle per read.
//  Latency: draw hit = 2 cycles SORTEIA->valid; worst case MAX_TRIES*2 + 2*W*H + 1.
//  Cell is checked at read time only; later changes to that cell are update's responsibility.
//  wx/wy always in range when valid=1; never change while valid=1.
// TESTING
//  Hold reset=0 3 cycles -> all outputs 0; release -> renable pulses within MAX_TRIES cycles.
//  Empty 80x60 map model, SEED=ACE1 -> valid within 64 cycles, wx<80, wy<60, model cell == 00.
//  Map all occupied except (7,5) -> after MAX_TRIES draws scan reads row-major; valid with wx=7, wy=5.
//  Map fully occupied -> exactly 4800 scan reads, then cheio=1, valid=0, renable stays 0.
//  In PRONTO pulse fruta_wenable -> valid=0 next cycle, new read starts; wx/wy never change while valid=1.
//  Assert reset=0 mid-scan (y=20) -> next cycle outputs 0, state SORTEIA, tries=0, lfsr=SEED.

Source files
------------

// File: rtl/fruta_gen.sv
// Fruit-position generator.
// Draws pseudo-random map cells from an LFSR, checks each one through a dedicated map read
// port, and presents the first empty cell found as (fruta_wx, fruta_wy) with fruta_valid.
// After MAX_TRIES draws with no hit it falls back to a row-major scan of the whole map.
// If the scan finds no empty cell, fruta_cheio is set and held until reset.
//
// Ports:
//   clk           clock
//   reset         synchronous active-low reset
//   fruta_renable map read strobe; rdata is valid the following cycle
//   fruta_rx/ry   map read column/row, meaningful only while fruta_renable is high
//   fruta_rdata   cell contents, 2'b00 = empty
//   fruta_wx/wy   validated fruit position, held while fruta_valid
//   fruta_valid   fruta_wx/wy hold an empty-checked cell
//   fruta_wenable consumer pulse: position taken, generate the next one
//   fruta_cheio   sticky map-full flag
module fruta_gen #(
    parameter int unsigned MAPA_WIDTH  = 80,
    parameter int unsigned MAPA_HEIGHT = 60,
    parameter logic [15:0] SEED        = 16'hACE1,
    parameter int unsigned MAX_TRIES   = 32
) (
    input  logic       clk,
    input  logic       reset,
    output logic       fruta_renable,
    output logic [9:0] fruta_rx,
    output logic [9:0] fruta_ry,
    input  logic [1:0] fruta_rdata,
    output logic [9:0] fruta_wx,
    output logic [9:0] fruta_wy,
    output logic       fruta_valid,
    input  logic       fruta_wenable,
    output logic       fruta_cheio
);

    localparam int unsigned XB = $clog2(MAPA_WIDTH);
    localparam int unsigned YB = $clog2(MAPA_HEIGHT);
    localparam int unsigned TW = $clog2(MAX_TRIES + 1);
    // An all-zero seed would lock the LFSR up.
    localparam logic [15:0]    SeedEff  = (SEED == 16'h0000) ? 16'hACE1 : SEED;
    localparam logic [10:0]    WLim     = 11'(MAPA_WIDTH);
    localparam logic [10:0]    HLim     = 11'(MAPA_HEIGHT);
    localparam logic [9:0]     XLast    = 10'(MAPA_WIDTH - 1);
    localparam logic [9:0]     YLast    = 10'(MAPA_HEIGHT - 1);
    localparam logic [TW-1:0]  TriesMax = TW'(MAX_TRIES);

    typedef enum logic [2:0] {
        StSorteia,
        StEspera,
        StVarre,
        StVarreEspera,
        StPronto,
        StCheio
    } state_e;

    state_e         state_q, state_d;
    logic [15:0]    lfsr_q;
    logic [TW-1:0]  tries_q, tries_d, tries_inc;
    logic [9:0]     rd_x_q, rd_x_d, rd_y_q, rd_y_d;
    logic [9:0]     scan_x_q, scan_x_d, scan_y_q, scan_y_d;
    logic [9:0]     wx_q, wx_d, wy_q, wy_d;
    logic           valid_q, valid_d, cheio_q, cheio_d;
    logic [9:0]     cx, cy;
    logic           cand_ok, rd_en;
    logic [9:0]     rd_addr_x, rd_addr_y;

    always_comb begin
        cx = '0;
        cy = '0;
        cx[XB-1:0] = lfsr_q[XB-1:0];
        cy[YB-1:0] = lfsr_q[15:16-YB];
    end

    assign cand_ok   = ({1'b0, cx} < WLim) && ({1'b0, cy} < HLim);
    assign tries_inc = tries_q + 1'b1;

    always_comb begin
        state_d   = state_q;
        tries_d   = tries_q;
        rd_x_d    = rd_x_q;
        rd_y_d    = rd_y_q;
        scan_x_d  = scan_x_q;
        scan_y_d  = scan_y_q;
        wx_d      = wx_q;
        wy_d      = wy_q;
        valid_d   = valid_q;
        cheio_d   = cheio_q;
        rd_en     = 1'b0;
        rd_addr_x = '0;
        rd_addr_y = '0;
        unique case (state_q)
            StSorteia: begin
                tries_d = tries_inc;
                // Exhausting the draw budget wins over a draw that happens to be in range.
                if (tries_inc == TriesMax) begin
                    scan_x_d = '0;
                    scan_y_d = '0;
                    state_d  = StVarre;
                end else if (cand_ok) begin
                    rd_en     = 1'b1;
                    rd_addr_x = cx;
                    rd_addr_y = cy;
                    rd_x_d    = cx;
                    rd_y_d    = cy;
                    state_d   = StEspera;
                end
            end
            StEspera: begin
                if (fruta_rdata == 2'b00) begin
                    wx_d    = rd_x_q;
                    wy_d    = rd_y_q;
                    valid_d = 1'b1;
                    state_d = StPronto;
                end else begin
                    state_d = StSorteia;
                end
            end
            StVarre: begin
                rd_en     = 1'b1;
                rd_addr_x = scan_x_q;
                rd_addr_y = scan_y_q;
                state_d   = StVarreEspera;
            end
            StVarreEspera: begin
                if (fruta_rdata == 2'b00) begin
                    wx_d    = scan_x_q;
                    wy_d    = scan_y_q;
                    valid_d = 1'b1;
                    state_d = StPronto;
                end else if (scan_x_q == XLast) begin
                    if (scan_y_q == YLast) begin
                        cheio_d = 1'b1;
                        state_d = StCheio;
                    end else begin
                        scan_x_d = '0;
                        scan_y_d = scan_y_q + 10'd1;
                        state_d  = StVarre;
                    end
                end else begin
                    scan_x_d = scan_x_q + 10'd1;
                    state_d  = StVarre;
                end
            end
            StPronto: begin
                if (fruta_wenable) begin
                    valid_d = 1'b0;
                    tries_d = '0;
                    state_d = StSorteia;
                end
            end
            StCheio: begin
                valid_d = 1'b0;
            end
            default: state_d = StSorteia;
        endcase
    end

    // The strobe is combinational from state so rdata lines up with the check state;
    // gating with reset keeps the read port quiet while reset is held.
    assign fruta_renable = rd_en & reset;
    assign fruta_rx      = (rd_en && reset) ? rd_addr_x : 10'd0;
    assign fruta_ry      = (rd_en && reset) ? rd_addr_y : 10'd0;
    assign fruta_wx      = wx_q;
    assign fruta_wy      = wy_q;
    assign fruta_valid   = valid_q;
    assign fruta_cheio   = cheio_q;

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= StSorteia;
            lfsr_q   <= SeedEff;
            tries_q  <= '0;
            rd_x_q   <= '0;
            rd_y_q   <= '0;
            scan_x_q <= '0;
            scan_y_q <= '0;
            wx_q     <= '0;
            wy_q     <= '0;
            valid_q  <= 1'b0;
            cheio_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            // Fibonacci taps 16,14,13,11; free-running regardless of state.
            lfsr_q   <= {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
            tries_q  <= tries_d;
            rd_x_q   <= rd_x_d;
            rd_y_q   <= rd_y_d;
            scan_x_q <= scan_x_d;
            scan_y_q <= scan_y_d;
            wx_q     <= wx_d;
            wy_q     <= wy_d;
            valid_q  <= valid_d;
            cheio_q  <= cheio_d;
        end
    end

endmodule
